// File: rtl/sorted_stream_sink_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : sorted_stream_sink_pkg                               |
// | Description : Shared types and constants for the sorted stream     |
// |               sink: state encoding and the word width it shares    |
// |               with the upstream sorter.                            |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package sorted_stream_sink_pkg;

   // Word width used by the sorter; the sink defaults to the same value
   localparam int SORTER_WIDTH = 32;

   // State encodings for the frame-capture FSM
   localparam logic [1:0] c_st_idle    = 2'd0;
   localparam logic [1:0] c_st_collect = 2'd1;
   localparam logic [1:0] c_st_done    = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = c_st_idle,
      ST_COLLECT = c_st_collect,
      ST_DONE    = c_st_done
   } sink_state_t;

endpackage : sorted_stream_sink_pkg
`default_nettype wire

// File: rtl/sorted_stream_sink_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : sink_regfile                                         |
// | Description : DEPTH x WIDTH register array with one write port and |
// |               one registered read port. Out-of-range reads return |
// |               zero; asynchronous active-low clear of all words.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module sink_regfile #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic                     clk,
   input  logic                     rst,        // active-low, asynchronous
   input  logic                     i_wr_en,
   input  logic [ADDR_W-1:0]        i_wr_addr,
   input  logic signed [WIDTH-1:0]  i_wr_data,
   input  logic [ADDR_W-1:0]        i_rd_addr,
   output logic signed [WIDTH-1:0]  o_rd_data
);

   logic signed [WIDTH-1:0] r_mem [DEPTH];
   logic                    w_wr_in_range;
   logic                    w_rd_in_range;

   // Addresses at or beyond DEPTH have no backing storage
   assign w_wr_in_range = (int'(i_wr_addr) < DEPTH);
   assign w_rd_in_range = (int'(i_rd_addr) < DEPTH);

   // Storage array: cleared on reset, written one word per cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wr_en && w_wr_in_range) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Registered read; a same-cycle write is not forwarded, so old data is returned
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_rd_data <= '0;
      end else if (w_rd_in_range) begin
         o_rd_data <= r_mem[i_rd_addr];
      end else begin
         o_rd_data <= '0;
      end
   end

endmodule : sink_regfile
`default_nettype wire

// File: rtl/sorted_stream_sink.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : sorted_stream_sink                                   |
// | Description : Captures one frame of DEPTH signed words from the    |
// |               sorter, stores them for random-access readback and   |
// |               flags any descending step, completion and overflow.  |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module sorted_stream_sink
   import sorted_stream_sink_pkg::*;
#(
   parameter int WIDTH  = SORTER_WIDTH,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic                     clk,
   input  logic                     rst,           // active-low, asynchronous
   input  logic signed [WIDTH-1:0]  data_serial_i,
   input  logic                     data_valid_i,
   input  logic                     clear_i,
   input  logic [ADDR_W-1:0]        rd_addr_i,
   output logic signed [WIDTH-1:0]  rd_data_o,
   output logic [ADDR_W:0]          count_o,
   output logic                     done_o,
   output logic                     order_err_o,
   output logic                     sorted_ok_o,
   output logic                     overflow_o
);

   localparam int              CNT_W       = ADDR_W + 1;
   localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

   sink_state_t              r_state;
   sink_state_t              w_state_nxt;
   logic [CNT_W-1:0]         r_count;
   logic [CNT_W-1:0]         w_count_nxt;
   logic signed [WIDTH-1:0]  r_prev;
   logic signed [WIDTH-1:0]  w_prev_nxt;
   logic                     r_order_err;
   logic                     w_order_err_nxt;
   logic                     r_overflow;
   logic                     w_overflow_nxt;
   logic                     w_wr_en;
   logic [ADDR_W-1:0]        w_wr_addr;

   // Next-state, datapath update and write-port control for the capture FSM
   always_comb begin
      w_state_nxt     = r_state;
      w_count_nxt     = r_count;
      w_prev_nxt      = r_prev;
      w_order_err_nxt = r_order_err;
      w_overflow_nxt  = r_overflow;
      w_wr_en         = 1'b0;
      w_wr_addr       = r_count[ADDR_W-1:0];

      if (clear_i) begin
         // Restart wins over any word arriving this cycle; memory is kept
         w_state_nxt     = ST_IDLE;
         w_count_nxt     = '0;
         w_order_err_nxt = 1'b0;
         w_overflow_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (data_valid_i) begin
                  w_wr_en     = 1'b1;
                  w_wr_addr   = '0;
                  w_prev_nxt  = data_serial_i;
                  w_count_nxt = c_one;
                  w_state_nxt = (DEPTH == 1) ? ST_DONE : ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (data_valid_i) begin
                  w_wr_en = 1'b1;
                  // Equal neighbours are legal; only a strict signed drop is an error
                  if (data_serial_i < r_prev) begin
                     w_order_err_nxt = 1'b1;
                  end
                  w_prev_nxt  = data_serial_i;
                  w_count_nxt = r_count + c_one;
                  if (r_count + c_one == c_depth_cnt) begin
                     w_state_nxt = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               // Frame is full: extra words are flagged and discarded
               if (data_valid_i) begin
                  w_overflow_nxt = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State, counter, previous-word and sticky flag registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_prev      <= '0;
         r_order_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_prev      <= w_prev_nxt;
         r_order_err <= w_order_err_nxt;
         r_overflow  <= w_overflow_nxt;
      end
   end

   sink_regfile #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (data_serial_i),
      .i_rd_addr (rd_addr_i),
      .o_rd_data (rd_data_o)
   );

   assign count_o     = r_count;
   assign done_o      = (r_state == ST_DONE);
   assign order_err_o = r_order_err;
   assign overflow_o  = r_overflow;
   assign sorted_ok_o = done_o & ~r_order_err;

endmodule : sorted_stream_sink
`default_nettype wire

// File: tb/tb_sorted_stream_sink.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_sorted_stream_sink                                |
// | Description : Directed self-checking bench for sorted_stream_sink. |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_sorted_stream_sink;

   logic               clk;
   logic               rst;
   logic signed [31:0] data_serial;
   logic               data_valid;
   logic               clear;
   logic [2:0]         rd_addr;
   logic signed [31:0] rd_data;
   logic [3:0]         count;
   logic               done;
   logic               order_err;
   logic               sorted_ok;
   logic               overflow;

   int n_vec;
   int n_err;

   int f_sorted [8] = '{-5, -1, 0, 0, 3, 7, 100, 2147483647};
   int f_bad    [8] = '{1, 2, 3, 2, 4, 5, 6, 7};

   sorted_stream_sink #(
      .WIDTH  (32),
      .DEPTH  (8),
      .ADDR_W (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .data_serial_i (data_serial),
      .data_valid_i  (data_valid),
      .clear_i       (clear),
      .rd_addr_i     (rd_addr),
      .rd_data_o     (rd_data),
      .count_o       (count),
      .done_o        (done),
      .order_err_o   (order_err),
      .sorted_ok_o   (sorted_ok),
      .overflow_o    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input int w);
      data_serial = w;
      data_valid  = 1'b1;
      tick();
      data_valid  = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic rd_check(input string tag, input int a, input int exp);
      rd_addr = 3'(a);
      tick();
      chk(tag, rd_data, exp);
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      rst         = 1'b0;
      data_serial = '0;
      data_valid  = 1'b0;
      clear       = 1'b0;
      rd_addr     = '0;

      // Reset state
      #3;
      chk("rst_count", count, 0);
      chk("rst_done", done, 0);
      chk("rst_err", order_err, 0);
      chk("rst_ok", sorted_ok, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_rd", rd_data, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Sorted frame on consecutive cycles
      for (int i = 0; i < 8; i++) begin
         send_word(f_sorted[i]);
         if (i == 6) chk("s1_done_early", done, 0);
      end
      chk("s1_done", done, 1);
      chk("s1_ok", sorted_ok, 1);
      chk("s1_count", count, 8);
      chk("s1_err", order_err, 0);
      chk("s1_ovf", overflow, 0);
      for (int i = 0; i < 8; i++) rd_check("s1_rd", i, f_sorted[i]);
      rd_addr = 3'd0;
      chk("s1_rd_latency", rd_data, 32'h7fffffff);
      tick();
      chk("s1_rd_after", rd_data, -5);

      // Order violation at the fourth word
      do_clear();
      chk("s2_clr_count", count, 0);
      chk("s2_clr_done", done, 0);
      for (int i = 0; i < 8; i++) begin
         send_word(f_bad[i]);
         if (i == 2) chk("s2_err_before", order_err, 0);
         if (i == 3) chk("s2_err_rise", order_err, 1);
      end
      chk("s2_err_sticky", order_err, 1);
      chk("s2_done", done, 1);
      chk("s2_ok", sorted_ok, 0);

      // Gapped frame then overflow
      do_clear();
      for (int i = 0; i < 8; i++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) tick();
         send_word(10 + i);
         chk("s3_count", count, i + 1);
      end
      chk("s3_done", done, 1);
      chk("s3_ok", sorted_ok, 1);
      send_word(9);
      chk("s3_ovf", overflow, 1);
      chk("s3_count_sat", count, 8);
      chk("s3_done_hold", done, 1);
      rd_check("s3_mem7", 7, 17);
      rd_check("s3_mem0", 0, 10);

      // Clear colliding with a valid word
      do_clear();
      for (int i = 0; i < 4; i++) send_word(20 + i);
      chk("s4_count4", count, 4);
      data_serial = 99;
      data_valid  = 1'b1;
      clear       = 1'b1;
      tick();
      data_valid  = 1'b0;
      clear       = 1'b0;
      chk("s4_count", count, 0);
      chk("s4_done", done, 0);
      chk("s4_err", order_err, 0);
      chk("s4_ovf", overflow, 0);
      rd_check("s4_dropped", 4, 14);
      for (int i = 0; i < 8; i++) send_word(30 + i);
      chk("s4_done2", done, 1);
      chk("s4_ok2", sorted_ok, 1);
      for (int i = 0; i < 8; i++) rd_check("s4_rd", i, 30 + i);

      // Asynchronous reset mid-frame
      do_clear();
      for (int i = 0; i < 5; i++) send_word(40 + i);
      rd_check("s5_pre", 2, 42);
      chk("s5_pre_count", count, 5);
      #2;
      rst = 1'b0;
      #1;
      chk("s5_async_count", count, 0);
      chk("s5_async_rd", rd_data, 0);
      #2;
      rst = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) rd_check("s5_rd_zero", i, 0);
      for (int i = 0; i < 8; i++) send_word(50 + i);
      chk("s5_done", done, 1);
      chk("s5_ok", sorted_ok, 1);
      rd_check("s5_rd3", 3, 53);

      // Signed extremes
      do_clear();
      send_word(int'(32'h80000000));
      send_word(2147483647);
      chk("s6_up_err", order_err, 0);
      do_clear();
      send_word(2147483647);
      send_word(int'(32'h80000000));
      chk("s6_down_err", order_err, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_sorted_stream_sink
`default_nettype wire
